// File: rtl/mdu_seq.sv
// mdu_seq: E-stage multiply/divide sequencer issuing starts, counting latency, committing HI/LO and stalling D.
module mdu_seq #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       i_e_valid,
  input  logic [3:0] i_e_op,
  input  logic       i_e_rt_zero,
  input  logic       i_d_is_md,
  output logic       o_mdu_start,
  output logic [3:0] o_mdu_op,
  output logic       o_mt_we,
  output logic       o_busy,
  output logic       o_hilo_we,
  output logic       o_stall_d,
  output logic       o_div_zero,
  output logic [3:0] o_cycles_left
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_div_zero;
  logic       w_arith;
  logic       w_mt;
  assign w_arith       = i_e_op >= 4'd1 && i_e_op <= 4'd4;
  assign w_mt          = i_e_op == 4'd7 || i_e_op == 4'd8;
  assign o_busy        = r_state == RUN;
  assign o_cycles_left = r_cnt;
  assign o_div_zero    = r_div_zero;
  // Combinational strobes stay quiet while reset is held so an in-flight op cannot commit.
  assign o_hilo_we     = !reset && o_busy && r_cnt == 4'd1;
  assign o_mdu_start   = !reset && !o_busy && i_e_valid && w_arith && !i_req;
  assign o_mt_we       = !reset && !o_busy && i_e_valid && w_mt && !i_req;
  assign o_stall_d     = !reset && i_d_is_md && (o_busy || o_mdu_start);
  assign o_mdu_op      = (o_mdu_start || o_mt_we) ? i_e_op : 4'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_div_zero <= 1'b0;
    end else if (r_state == IDLE) begin
      if (o_mdu_start) begin
        r_state    <= RUN;
        r_cnt      <= i_e_op <= 4'd2 ? 4'(MULT_LAT) : 4'(DIV_LAT);
        r_div_zero <= r_div_zero | (i_e_op >= 4'd3 && i_e_rt_zero);
      end
    end else begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) r_state <= IDLE;
    end
  end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Sequencer for the E-stage multiply/divide unit. It decodes the MDU operation class presented in E and issues a single-cycle start to the arithmetic datapath. It counts the fixed multi-cycle latency, raises the HI/LO commit strobe, and generates the D-stage stall for any MDU-class instruction that would collide with an in-flight operation. It also gates issue against an interrupt/exception request so that a flushed E-stage instruction never starts the unit.

## Interface
- MULT_LAT, 5, busy cycles for mult/multu (legal 2..15)
- DIV_LAT, 10, busy cycles for div/divu (legal 2..15)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt request; E-stage instruction is being flushed this cycle
- e_valid  in  1  E-stage holds a valid instruction
- e_op  in  4  MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
- e_rt_zero  in  1  E-stage rt operand equals 0
- d_is_md  in  1  D-stage instruction is any of ops 1-8
- mdu_start  out  1  start pulse to datapath
- mdu_op  out  4  op forwarded to datapath; equals e_op when mdu_start or mt_we is 1, else 0
- mt_we  out  1  mthi/mtlo write strobe
- busy  out  1  arithmetic op in flight
- hilo_we  out  1  commit tmp result to HI/LO
- stall_d  out  1  stall D stage
- div_zero  out  1  sticky flag: a div/divu was started with rt == 0
- cycles_left  out  4  remaining busy cycles, 0 when idle

## Operation
- Arithmetic class is ops 1-4. Move class is ops 5-8. mthi/mtlo are ops 7-8.
- FSM states:
  - IDLE: busy=0, cycles_left=0.
  - RUN: busy=1.
- In IDLE:
  - mdu_start = e_valid & arith(e_op) & !req (combinational).
  - When mdu_start is 1: state moves to RUN and cycles_left loads MULT_LAT (ops 1-2) or DIV_LAT (ops 3-4).
- In RUN:
  - cycles_left decrements each cycle.
  - hilo_we = 1 while cycles_left == 1. On that cycle state returns to IDLE and cycles_left goes to 0.
  - mdu_start is forced to 0, even if E presents an arithmetic op.
  - An E-stage op presented during RUN is a pipeline error. It is ignored; stall_d prevents it.
- mt_we = e_valid & (e_op == 7 | e_op == 8) & !req & !busy.
- stall_d = d_is_md & (busy | mdu_start).
- div_zero is set when mdu_start is 1 with op 3/4 and e_rt_zero is 1. It is cleared only by reset.
- req does not abort an op already in RUN. The countdown and commit proceed unchanged, so an in-flight op is architecturally committed.
- reset in any state has priority over every other input:
  - State goes to IDLE.
  - busy, hilo_we, div_zero and cycles_left go to 0.
  - Any in-flight op is dropped with no hilo_we.

## Timing
- Reset values: mdu_start 0, mdu_op 0, mt_we 0, busy 0, hilo_we 0, stall_d 0, div_zero 0, cycles_left 0. Combinational outputs depend on inputs only after reset is released.
- Arithmetic op with start in cycle T:
  - busy = 1 in cycles T+1 .. T+LAT.
  - cycles_left = LAT in T+1, down to 1 in T+LAT.
  - hilo_we = 1 in cycle T+LAT only.
  - IDLE from T+LAT+1. A new start is allowed in T+LAT+1.
- Back-to-back: an arithmetic op in E at T+LAT+1 starts at T+LAT+1, giving a gap of exactly 0 idle cycles.
- stall_d is high in cycles T .. T+LAT whenever d_is_md is 1. It is low in T+LAT+1.
- mthi/mtlo take effect in the cycle presented (mt_we pulse, 1 cycle). They are never stalled while IDLE.
- Simultaneous req and arithmetic e_op in IDLE: no start, state stays IDLE, stall_d = 0.

## Test plan
- Reset, then mult in E at cycle 2 with MULT_LAT=5 -> mdu_start=1 at 2; busy at 3-7; cycles_left 5,4,3,2,1; hilo_we only at 7; busy=0 at 8.
- div with e_rt_zero=1, DIV_LAT=10, d_is_md=1 throughout -> div_zero=1 from next cycle and stays 1; stall_d=1 for 11 cycles (start cycle through last busy cycle); hilo_we at start+10.
- divu start at cycle 4, req=1 at cycle 6 -> countdown continues; hilo_we at cycle 14; no restart.
- req=1 in the same cycle as a multu in E while IDLE -> mdu_start=0, busy stays 0, mdu_op=0.
- reset asserted at cycle 3 of a 10-cycle div -> busy=0, cycles_left=0 next cycle; hilo_we never asserts; div_zero cleared.
- mult completes at T+5; multu presented at T+6 -> second start at T+6; hilo_we at T+5 and T+11; mtlo presented while busy -> mt_we=0.
